// File: rtl/torreta_pkg.sv
// Shared types and constants for the turret serial arbiter.
package torreta_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned FRAME_W = 32;
    localparam int unsigned LEN_W   = 2;

    localparam logic [BYTE_W-1:0] DELIMITADOR = 8'h23;

    typedef enum logic [3:0] {
        OCIOSO       = 4'd0,
        CONCEDE      = 4'd1,
        ENVIA        = 4'd2,
        ESPERA       = 4'd3,
        DELIM        = 4'd4,
        ESPERA_DELIM = 4'd5,
        FIM          = 4'd6,
        ABORTA       = 4'd7
    } estado_t;

    // Byte idx of a frame; idx 3 is the most-significant byte.
    function automatic logic [BYTE_W-1:0] sel_byte(input logic [FRAME_W-1:0] frame,
                                                   input logic [LEN_W-1:0]   idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = frame[7:0];
            2'd1:    b = frame[15:8];
            2'd2:    b = frame[23:16];
            default: b = frame[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/torreta_rr_arbitro.sv
// Combinational round-robin winner selection for the serial arbiter.
// With TORRETA_PRIORIDADE_AMEACA_EN defined, requester 0 (threat alert)
// always wins; the rest share round-robin order.
module torreta_rr_arbitro
    import torreta_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [N_REQ-1:0] win_onehot_o,
    output logic [IDX_W-1:0] win_idx_o
);

    int unsigned pos;

    // Search upward from the pointer, wrapping at N_REQ-1; first hit wins.
    always_comb begin
        valid_o      = 1'b0;
        win_idx_o    = '0;
        win_onehot_o = '0;
        pos          = 0;
`ifdef TORRETA_PRIORIDADE_AMEACA_EN
        if (req_i[0]) begin
            valid_o   = 1'b1;
            win_idx_o = '0;
        end
`endif
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (32'(ptr_i) + k) % N_REQ;
            if (!valid_o && req_i[IDX_W'(pos)]) begin
                valid_o   = 1'b1;
                win_idx_o = IDX_W'(pos);
            end
        end
        if (valid_o) begin
            win_onehot_o[win_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/torreta_arbitro_serial.sv
// Shares the single UART transmitter among N_REQ frame requesters.
// Frames of 1-4 bytes are sent MSB-first and terminated by '#'.
// Optional build macro: TORRETA_PRIORIDADE_AMEACA_EN (requester 0 always wins).
module torreta_arbitro_serial
    import torreta_pkg::*;
#(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*FRAME_W-1:0]   dados,
    input  logic [N_REQ*LEN_W-1:0]     tamanho,
    output logic [N_REQ-1:0]           grant,
    output logic                       tx_partida,
    output logic [BYTE_W-1:0]          tx_dados,
    input  logic                       tx_pronto,
    output logic                       fim_envio,
    output logic                       erro_timeout,
    output logic                       ocupado,
    output logic [3:0]                 db_estado
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

    estado_t              estado_q, estado_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [LEN_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic                 partida_q, partida_d;
    logic [BYTE_W-1:0]    tx_dados_q, tx_dados_d;
    logic                 fim_q, fim_d;
    logic                 erro_q, erro_d;
    logic                 ocupado_q, ocupado_d;

    logic                 rr_valid;
    logic [N_REQ-1:0]     rr_onehot;
    logic [IDX_W-1:0]     rr_idx;
    logic [FRAME_W-1:0]   cap_frame;
    logic [LEN_W-1:0]     cap_len;
    logic [CNT_W-1:0]     cnt_inc;
    logic [IDX_W-1:0]     ptr_after;

    torreta_rr_arbitro #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i        (req),
        .ptr_i        (ptr_q),
        .valid_o      (rr_valid),
        .win_onehot_o (rr_onehot),
        .win_idx_o    (rr_idx)
    );

    // Payload and length slice of the registered winner.
    always_comb begin
        cap_frame = '0;
        cap_len   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == win_q) begin
                cap_frame = dados[i*FRAME_W +: FRAME_W];
                cap_len   = tamanho[i*LEN_W +: LEN_W];
            end
        end
    end

    // Pointer value once the current frame ends.
    always_comb begin
        ptr_after = (win_q == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(win_q + 1'b1);
`ifdef TORRETA_PRIORIDADE_AMEACA_EN
        if (win_q == '0) begin
            ptr_after = ptr_q;
        end
`endif
    end

    assign cnt_inc = cnt_q + 1'b1;

    // Next-state and registered-output decode.
    always_comb begin
        estado_d   = estado_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        frame_d    = frame_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        grant_d    = '0;
        partida_d  = 1'b0;
        tx_dados_d = tx_dados_q;
        fim_d      = 1'b0;
        erro_d     = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (rr_valid) begin
                    win_d    = rr_idx;
                    grant_d  = rr_onehot;
                    estado_d = CONCEDE;
                end
            end
            CONCEDE: begin
                frame_d    = cap_frame;
                idx_d      = cap_len;
                partida_d  = 1'b1;
                tx_dados_d = sel_byte(cap_frame, cap_len);
                estado_d   = ENVIA;
            end
            ENVIA: begin
                cnt_d    = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (tx_pronto) begin
                    partida_d = 1'b1;
                    if (idx_q != '0) begin
                        idx_d      = idx_q - 1'b1;
                        tx_dados_d = sel_byte(frame_q, idx_q - 1'b1);
                        estado_d   = ENVIA;
                    end else begin
                        tx_dados_d = DELIMITADOR;
                        estado_d   = DELIM;
                    end
                end else if (cnt_inc == CNT_LIM) begin
                    erro_d   = 1'b1;
                    estado_d = ABORTA;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DELIM: begin
                cnt_d    = '0;
                estado_d = ESPERA_DELIM;
            end
            ESPERA_DELIM: begin
                if (tx_pronto) begin
                    fim_d    = 1'b1;
                    estado_d = FIM;
                end else if (cnt_inc == CNT_LIM) begin
                    erro_d   = 1'b1;
                    estado_d = ABORTA;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            FIM, ABORTA: begin
                ptr_d    = ptr_after;
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
        ocupado_d = (estado_d != OCIOSO);
    end

    // State, frame and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            ptr_q      <= '0;
            win_q      <= '0;
            frame_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            partida_q  <= 1'b0;
            tx_dados_q <= '0;
            fim_q      <= 1'b0;
            erro_q     <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            partida_q  <= partida_d;
            tx_dados_q <= tx_dados_d;
            fim_q      <= fim_d;
            erro_q     <= erro_d;
            ocupado_q  <= ocupado_d;
        end
    end

    assign grant        = grant_q;
    assign tx_partida   = partida_q;
    assign tx_dados     = tx_dados_q;
    assign fim_envio    = fim_q;
    assign erro_timeout = erro_q;
    assign ocupado      = ocupado_q;
    assign db_estado    = estado_q;

endmodule

// File: tb/tb_torreta_arbitro_serial.sv
// Directed bench for torreta_arbitro_serial with a byte/grant scoreboard.
module tb_torreta_arbitro_serial;

    localparam int unsigned N_REQ   = 3;
    localparam int unsigned TIMEOUT = 20;

    logic        clock;
    logic        reset;
    logic [2:0]  req;
    logic [95:0] dados;
    logic [5:0]  tamanho;
    logic [2:0]  grant;
    logic        tx_partida;
    logic [7:0]  tx_dados;
    logic        tx_pronto;
    logic        fim_envio;
    logic        erro_timeout;
    logic        ocupado;
    logic [3:0]  db_estado;

    logic        pronto_uart;
    logic        pronto_man;
    bit          uart_en;
    int          uart_lat;

    int checks    = 0;
    int errors    = 0;
    int fim_cnt   = 0;
    int erro_cnt  = 0;
    int grant_cnt = 0;

    logic [7:0] exp_bytes[$];
    logic [2:0] exp_grants[$];

    assign tx_pronto = pronto_uart | pronto_man;

    torreta_arbitro_serial #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .dados        (dados),
        .tamanho      (tamanho),
        .grant        (grant),
        .tx_partida   (tx_partida),
        .tx_dados     (tx_dados),
        .tx_pronto    (tx_pronto),
        .fim_envio    (fim_envio),
        .erro_timeout (erro_timeout),
        .ocupado      (ocupado),
        .db_estado    (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grants(input int target, input string tag);
        int t = 0;
        while (grant_cnt < target && t < 2000) begin
            @(negedge clock);
            t++;
        end
        check(tag, grant_cnt, target);
    endtask

    task automatic wait_fim(input int target, input string tag);
        int t = 0;
        while (fim_cnt < target && t < 2000) begin
            @(negedge clock);
            t++;
        end
        check(tag, fim_cnt, target);
    endtask

    // UART model: answers each start pulse with a one-cycle tx_pronto.
    initial begin
        pronto_uart = 1'b0;
        forever begin
            @(negedge clock);
            pronto_uart = 1'b0;
            if (reset && tx_partida && uart_en) begin
                repeat (uart_lat) @(negedge clock);
                pronto_uart = 1'b1;
            end
        end
    end

    // Scoreboard: every start pulse and grant must match the next expected entry.
    always @(negedge clock) begin
        logic       has;
        logic [7:0] eb;
        logic [2:0] eg;
        if (reset) begin
            if (tx_partida) begin
                has = (exp_bytes.size() != 0);
                eb  = has ? exp_bytes.pop_front() : 8'h00;
                checks++;
                assert (has && tx_dados === eb) else begin
                    errors++;
                    $error("FAIL tx_byte observed=%02h expected=%02h pending=%0d", tx_dados, eb, has);
                end
            end
            if (grant != '0) begin
                grant_cnt++;
                has = (exp_grants.size() != 0);
                eg  = has ? exp_grants.pop_front() : 3'b000;
                checks++;
                assert (has && $onehot(grant) && grant === eg) else begin
                    errors++;
                    $error("FAIL grant observed=%03b expected=%03b pending=%0d", grant, eg, has);
                end
            end
            if (fim_envio)    fim_cnt++;
            if (erro_timeout) erro_cnt++;
        end
    end

    initial begin
        int t;
        int n;
        reset      = 1'b0;
        req        = '0;
        dados      = '0;
        tamanho    = '0;
        pronto_man = 1'b0;
        uart_en    = 1'b1;
        uart_lat   = 1;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_grant", 32'(grant), 0);
        check("rst_partida", 32'(tx_partida), 0);
        check("rst_tx_dados", 32'(tx_dados), 0);
        check("rst_fim", 32'(fim_envio), 0);
        check("rst_erro", 32'(erro_timeout), 0);
        check("rst_ocupado", 32'(ocupado), 0);
        check("rst_estado", 32'(db_estado), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single 3-byte frame from requester 1, with latency checks
        dados[63:32]  = 32'h00313233;
        tamanho[3:2]  = 2'd2;
        exp_grants.push_back(3'b010);
        exp_bytes.push_back(8'h31);
        exp_bytes.push_back(8'h32);
        exp_bytes.push_back(8'h33);
        exp_bytes.push_back(8'h23);
        req = 3'b010;
        @(posedge clock); #1;
        check("lat_grant", 32'(grant), 32'h2);
        check("lat_concede", 32'(db_estado), 1);
        req = 3'b000;
        @(posedge clock); #1;
        check("lat_partida", 32'(tx_partida), 1);
        check("lat_first_byte", 32'(tx_dados), 32'h31);
        wait_fim(1, "frame1_fim");
        repeat (2) @(negedge clock);
        check("frame1_idle", 32'(db_estado), 0);
        check("frame1_no_erro", 32'(erro_cnt), 0);

        // Stray tx_pronto in OCIOSO and CONCEDE
        pronto_man = 1'b1;
        @(negedge clock);
        pronto_man = 1'b0;
        check("stray_idle_state", 32'(db_estado), 0);
        check("stray_idle_partida", 32'(tx_partida), 0);
        dados[95:64] = 32'hAABBCCDD;
        tamanho[5:4] = 2'd1;
        uart_lat     = 3;
        exp_grants.push_back(3'b100);
        exp_bytes.push_back(8'hCC);
        exp_bytes.push_back(8'hDD);
        exp_bytes.push_back(8'h23);
        req = 3'b100;
        @(posedge clock); #1;
        check("stray_concede", 32'(db_estado), 1);
        pronto_man = 1'b1;
        @(posedge clock); #1;
        pronto_man = 1'b0;
        req        = 3'b000;
        check("stray_envia", 32'(db_estado), 2);
        check("stray_first_byte", 32'(tx_dados), 32'hCC);
        @(posedge clock); #1;
        check("stray_espera", 32'(db_estado), 3);
        wait_fim(2, "stray_fim");
        repeat (2) @(negedge clock);

        // Round-robin with all requesters held, 1-byte frames
        dados    = {32'h00000043, 32'h00000042, 32'h00000041};
        tamanho  = '0;
        uart_lat = 10;
        exp_grants.push_back(3'b001); exp_bytes.push_back(8'h41); exp_bytes.push_back(8'h23);
        exp_grants.push_back(3'b010); exp_bytes.push_back(8'h42); exp_bytes.push_back(8'h23);
        exp_grants.push_back(3'b100); exp_bytes.push_back(8'h43); exp_bytes.push_back(8'h23);
        exp_grants.push_back(3'b001); exp_bytes.push_back(8'h41); exp_bytes.push_back(8'h23);
        req = 3'b111;
        wait_grants(6, "rr_grants");
        req = 3'b000;
        wait_fim(6, "rr_fim");
        repeat (2) @(negedge clock);

        // Threat priority: requester 0 raised during the frame from requester 1
        uart_lat = 2;
        exp_grants.push_back(3'b010); exp_bytes.push_back(8'h42); exp_bytes.push_back(8'h23);
        req = 3'b110;
        wait_grants(7, "prio_first");
        req = 3'b101;
`ifdef TORRETA_PRIORIDADE_AMEACA_EN
        exp_grants.push_back(3'b001); exp_bytes.push_back(8'h41); exp_bytes.push_back(8'h23);
        exp_grants.push_back(3'b100); exp_bytes.push_back(8'h43); exp_bytes.push_back(8'h23);
`else
        exp_grants.push_back(3'b100); exp_bytes.push_back(8'h43); exp_bytes.push_back(8'h23);
        exp_grants.push_back(3'b001); exp_bytes.push_back(8'h41); exp_bytes.push_back(8'h23);
`endif
        wait_grants(9, "prio_rest");
        req = 3'b000;
        wait_fim(9, "prio_fim");
        repeat (2) @(negedge clock);

        // Timeout: UART silent, no delimiter, abort after TIMEOUT cycles
        uart_en = 1'b0;
        exp_grants.push_back(3'b010);
        exp_bytes.push_back(8'h42);
        req = 3'b010;
        t = 0;
        while (!tx_partida && t < 50) begin
            @(negedge clock);
            t++;
        end
        req = 3'b000;
        check("to_partida_seen", 32'(tx_partida), 1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!erro_timeout && n < 100);
        check("to_latency", 32'(n), 20);
        @(negedge clock);
        check("to_erro_count", 32'(erro_cnt), 1);
        check("to_no_fim", 32'(fim_cnt), 9);
        check("to_idle", 32'(db_estado), 0);
        check("to_ocupado", 32'(ocupado), 0);
        repeat (3) @(negedge clock);

        // Asynchronous reset while waiting for the UART
        exp_grants.push_back(3'b100);
        exp_bytes.push_back(8'h43);
        req = 3'b100;
        t = 0;
        while (db_estado != 4'd3 && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("mid_reach_espera", 32'(db_estado), 3);
        req   = 3'b000;
        reset = 1'b0;
        #1;
        check("mid_rst_estado", 32'(db_estado), 0);
        check("mid_rst_ocupado", 32'(ocupado), 0);
        check("mid_rst_partida", 32'(tx_partida), 0);
        check("mid_rst_tx_dados", 32'(tx_dados), 0);
        check("mid_rst_grant", 32'(grant), 0);
        check("mid_rst_fim", 32'(fim_envio), 0);
        check("mid_rst_erro", 32'(erro_timeout), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("mid_post_estado", 32'(db_estado), 0);
        check("mid_post_fim", 32'(fim_cnt), 9);
        check("mid_post_erro", 32'(erro_cnt), 1);

        // Everything expected was produced
        check("sb_bytes_left", 32'(exp_bytes.size()), 0);
        check("sb_grants_left", 32'(exp_grants.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/torreta_arbitro_serial.md
Name: torreta_arbitro_serial

Overview:
- Shares the turret's single UART transmitter between several requesters: distance/angle report, threat alert and ammunition-count report.
- Each requester presents a frame of 1–4 bytes. The block picks a requester, latches its frame, and sends the bytes one at a time through the transmitter's start/ready handshake.
- Every frame ends with the delimiter '#'.
- Sits between the turret control unit/datapath and the serial TX sub-block.

Parameters:
- N_REQ, 3, number of requesters; index 0 is the threat-alert source.
- TIMEOUT, 50000, max clock cycles to wait for tx_pronto per byte before aborting the frame.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per requester; held until its grant.
- dados  in  N_REQ*32  frame payload per requester; slice i = bits [32i+31:32i].
- tamanho  in  N_REQ*2  frame length minus 1 per requester (0 means 1 byte, 3 means 4 bytes).
- grant  out  N_REQ  one-hot, one-cycle pulse; the winner's payload is captured on this cycle.
- tx_partida  out  1  one-cycle start pulse to the UART.
- tx_dados  out  8  byte to transmit; valid while tx_partida=1 and held until the next send.
- tx_pronto  in  1  UART "byte finished" pulse.
- fim_envio  out  1  one-cycle pulse after the delimiter completes.
- erro_timeout  out  1  one-cycle pulse when a frame is aborted.
- ocupado  out  1  high in every state except OCIOSO.
- db_estado  out  4  state code for the hex display.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to OCIOSO.
  - All outputs go to 0; tx_dados goes to 8'h00.
  - Round-robin pointer goes to 0; byte index, timeout counter and frame registers are cleared.
  - Applies in any state. An in-flight byte is abandoned, with no fim_envio or erro_timeout pulse.
- States and db_estado codes: OCIOSO=0, CONCEDE=1, ENVIA=2, ESPERA=3, DELIM=4, ESPERA_DELIM=5, FIM=6, ABORTA=7.
- OCIOSO:
  - If any req bit is 1 at the clock edge, the winner is registered and the next state is CONCEDE.
  - Winner selection: round-robin, searching upward from the pointer and wrapping at N_REQ-1 to 0.
- CONCEDE (1 cycle):
  - grant[w]=1.
  - dados/tamanho slice w is captured into the frame registers; byte index = tamanho.
  - Next state: ENVIA.
- ENVIA (1 cycle):
  - tx_partida=1; tx_dados = frame[8*idx+7 : 8*idx], so the most-significant used byte goes first.
  - Timeout counter cleared; next state: ESPERA.
- ESPERA:
  - tx_pronto=1: if idx>0, decrement idx and go to ENVIA; otherwise go to DELIM.
  - Counter reaches TIMEOUT-1 without tx_pronto: go to ABORTA.
  - tx_pronto and timeout in the same cycle: tx_pronto wins.
- DELIM: tx_partida=1, tx_dados=8'h23; next state ESPERA_DELIM.
- ESPERA_DELIM: same timeout rules as ESPERA; tx_pronto goes to FIM.
- FIM (1 cycle): fim_envio=1; pointer = w+1 modulo N_REQ; next state OCIOSO.
- ABORTA (1 cycle): erro_timeout=1; pointer = w+1 modulo N_REQ; next state OCIOSO, with no delimiter sent.
- tx_pronto outside ESPERA/ESPERA_DELIM is ignored.
- Latency:
  - req first seen at edge k gives grant in cycle k+1 and the first tx_partida in cycle k+2.
  - Minimum frame (1 byte, zero-latency UART) is 6 cycles OCIOSO→OCIOSO.
- Request rules:
  - req changes after grant are ignored for the current frame.
  - A req dropped before its grant is not served.
  - A req still high after its own fim_envio is served again only after the others, by round-robin order.
- Back-to-back frames: OCIOSO lasts at least one cycle between frames.

Optional Feature:
- Macro: TORRETA_PRIORIDADE_AMEACA_EN.
- Defined: in OCIOSO, req[0] always wins regardless of the pointer. Other requesters use round-robin among themselves. The pointer is not advanced after a frame from requester 0.
- Undefined: pure round-robin across all N_REQ requesters.
- Timing is identical in both cases.

Decomposition:
- Package torreta_pkg holds:
  - state encoding (OCIOSO..ABORTA, 4-bit);
  - DELIMITADOR = 8'h23;
  - byte/frame width constants (8, 32, length field 2).
- Sub-module torreta_rr_arbitro:
  - inputs: req vector and pointer; outputs: one-hot winner and its index;
  - purely combinational, with the priority macro applied inside it.
- The FSM, timeout counter and frame registers stay in torreta_arbitro_serial.

Test Plan:
- Reset mid-send: drop reset to 0 during ESPERA → all outputs 0 within the same cycle, no fim_envio; after release, db_estado=0.
- Single frame: req[1]=1, dados[63:32]=32'h00313233, tamanho=2 → tx_dados sequence 0x31, 0x32, 0x33, 0x23, each paired with one tx_partida; then one fim_envio pulse.
- Round-robin: req=3'b111 held, each frame 1 byte, UART answers tx_pronto after 10 cycles → grants in order 0, 1, 2, 0; exactly one grant bit per frame.
- Timeout: TIMEOUT=20, tx_pronto never asserted → erro_timeout pulses 20 cycles after the first tx_partida, no 0x23 is sent, back in OCIOSO.
- Priority macro defined: req=3'b110 then req[0] raised during the frame from requester 1 → the next grant goes to 0 before 2; with the macro undefined → the next grant goes to 2.
- Stray handshake: tx_pronto pulsed in OCIOSO and in CONCEDE → no state change beyond normal sequencing; byte count unchanged.
